simon_btn_conditioner: RTL and testbench

// - Input-side counterpart of the game's LED/7-seg/sound outputs: conditions the 4 raw push-buttons (io_in[11:8])

---
 rtl/simon_btn_conditioner.sv | 100 ++++++++++
 tb/tb_simon_btn_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_btn_conditioner.sv
// simon_btn_conditioner: synchronise, ms-debounce, edge-detect and queue one press event for the game core.
// Optional BTN_LOCKOUT_EN: while any button is held, presses of the other buttons are masked.
module simon_btn_conditioner #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10,
    localparam int IDXW       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        ticks_per_milli,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               press_valid,
    output logic [IDXW-1:0]    press_idx,
    input  logic               press_ready,
    output logic               overrun,
    input  logic               overrun_clr
);
    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic [NUM_BTN-1:0]         s1_q, s2_q, level_q, level_d, press_q, press_d, release_q, release_d;
    logic [NUM_BTN-1:0]         flip, rise;
    logic [NUM_BTN-1:0][CW-1:0] dcnt_q, dcnt_d;
    logic [15:0]                cnt_q, cnt_d, tpm_m1;
    logic                       ms_tick, slot_free, set_ovr;
    logic                       valid_q, valid_d, ovr_q, ovr_d;
    logic [IDXW-1:0]            idx_q, idx_d, low_idx;

    always_comb begin
        tpm_m1    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
        ms_tick   = cnt_q >= tpm_m1;
        cnt_d     = ms_tick ? 16'd0 : cnt_q + 16'd1;
        level_d   = level_q;
        dcnt_d    = dcnt_q;
        flip      = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (s2_q[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (ms_tick) begin
                if (dcnt_q[i] + 1'b1 == CW'(DEBOUNCE_MS)) begin
                    flip[i]    = 1'b1;
                    level_d[i] = s2_q[i];
                    dcnt_d[i]  = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
        rise      = flip & s2_q;
`ifdef BTN_LOCKOUT_EN
        press_d   = (|level_q) ? '0 : rise & (~rise + 1'b1);
`else
        press_d   = rise;
`endif
        release_d = flip & ~s2_q;
        low_idx   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (press_q[i]) low_idx = IDXW'(i);
        slot_free = !valid_q | press_ready;
        set_ovr   = (|press_q) & (!slot_free | (|(press_q & (press_q - 1'b1))));
        valid_d   = (|press_q) ? (valid_q | slot_free) : (valid_q & !press_ready);
        idx_d     = ((|press_q) & slot_free) ? low_idx : idx_q;
        ovr_d     = set_ovr | (ovr_q & !overrun_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            dcnt_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ovr_q     <= ovr_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_valid = valid_q;
    assign press_idx   = idx_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_simon_btn_conditioner.sv
// tb_simon_btn_conditioner: directed scenarios plus random button traffic, checked every cycle
// against a behavioural model of the conditioner (DEBOUNCE_MS=3).
module tb_simon_btn_conditioner;
    localparam int DM = 3;

    logic        clk, rst, press_ready, overrun_clr, press_valid, overrun;
    logic [15:0] tpm;
    logic [3:0]  btn_raw, btn_level, btn_press, btn_release;
    logic [1:0]  press_idx;

    int n_chk, n_fail;

    bit [3:0] m_p0, m_p1, m_lvl, m_press, m_rel;
    int       m_cnt, m_idx;
    int       m_div[4];
    bit       m_valid, m_ovr;

    simon_btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_MS(DM)) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .press_valid(press_valid), .press_idx(press_idx), .press_ready(press_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p0 = 0; m_p1 = 0; m_lvl = 0; m_press = 0; m_rel = 0;
        m_cnt = 0; m_idx = 0; m_valid = 0; m_ovr = 0;
        foreach (m_div[i]) m_div[i] = 0;
    endtask

    // One clock edge of the intended behaviour, computed from the values seen before the edge.
    task automatic model_update();
        int lim, lo;
        bit tick, set_o;
        bit [3:0] nl, np, nr, rise;
        if (rst) begin
            model_reset();
            return;
        end
        lim  = (tpm == 0) ? 1 : int'(tpm);
        tick = m_cnt >= lim - 1;
        lo = 0;
        for (int i = 3; i >= 0; i--) if (m_press[i]) lo = i;
        set_o = 0;
        if (m_press != 0) begin
            if (!m_valid || press_ready) begin
                m_valid = 1;
                m_idx   = lo;
                set_o   = $countones(m_press) > 1;
            end else begin
                set_o = 1;
            end
        end else if (m_valid && press_ready) begin
            m_valid = 0;
        end
        m_ovr = set_o ? 1'b1 : (overrun_clr ? 1'b0 : m_ovr);
        nl = m_lvl; rise = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_p1[i] == m_lvl[i]) m_div[i] = 0;
            else if (tick) begin
                m_div[i]++;
                if (m_div[i] == DM) begin
                    nl[i] = m_p1[i];
                    m_div[i] = 0;
                    if (m_p1[i]) rise[i] = 1; else nr[i] = 1;
                end
            end
        end
`ifdef BTN_LOCKOUT_EN
        np = 0;
        if (m_lvl == 0)
            for (int i = 0; i < 4; i++) if (rise[i]) begin np[i] = 1; break; end
`else
        np = rise;
`endif
        m_cnt   = tick ? 0 : m_cnt + 1;
        m_p1    = m_p0;
        m_p0    = btn_raw;
        m_lvl   = nl;
        m_press = np;
        m_rel   = nr;
    endtask

    task automatic check_all();
        chk("level", btn_level, m_lvl);
        chk("press", btn_press, m_press);
        chk("release", btn_release, m_rel);
        chk("valid", press_valid, m_valid);
        chk("idx", press_idx, m_idx);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1; tpm = 16'd4; btn_raw = 0; press_ready = 0; overrun_clr = 0;
        model_reset();
        run(3);
        rst = 0;

        // Async reset mid-count with button 1 held
        btn_raw = 4'b0010;
        run(7);
        rst = 1;
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_valid", press_valid, 0);
        chk("rst_idx", press_idx, 0);
        model_reset();
        run(2);
        rst = 0;
        run(16);
        chk("rst_lvl1", btn_level, 4'b0010);
        chk("rst_ev_valid", press_valid, 1);
        chk("rst_ev_idx", press_idx, 1);

        btn_raw = 0; press_ready = 1;
        run(20);
        press_ready = 0;

        // Bounce shorter than a stable window
        for (int k = 0; k < 40; k += 3) begin
            btn_raw[2] = ~btn_raw[2];
            run(3);
        end
        btn_raw = 0;
        run(20);
        chk("bounce_level", btn_level, 0);
        chk("bounce_valid", press_valid, 0);

        // Handshake with a blocked consumer
        btn_raw = 4'b1000;
        run(20);
        run(50);
        chk("hs_valid", press_valid, 1);
        chk("hs_idx", press_idx, 3);
        btn_raw = 4'b1001;
        run(20);
        chk("hs_idx_held", press_idx, 3);
        press_ready = 1;
        step();
        press_ready = 0;
        step();
        chk("hs_consumed", press_valid, 0);
        overrun_clr = 1;
        step();
        overrun_clr = 0;
        chk("hs_ovr_clr", overrun, 0);
        btn_raw = 0;
        run(20);

        // Simultaneous presses
        btn_raw = 4'b1010;
        run(20);
        press_ready = 1;
        btn_raw = 0;
        run(20);

        // Back-to-back with tick every cycle
        tpm = 0;
        btn_raw = 4'b0001;
        step();
        btn_raw = 4'b0101;
        run(10);
        btn_raw = 0;
        run(10);

        // Lowering tpm mid-count
        rst = 1;
        step();
        model_reset();
        rst = 0;
        tpm = 16'd100;
        run(50);
        tpm = 16'd4;
        btn_raw = 4'b0100;
        run(30);
        btn_raw = 0;
        run(30);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) tpm = 16'($urandom_range(0, 5));
            btn_raw = 4'($urandom);
            for (int c = int'($urandom_range(1, 4)) * ($urandom_range(0, 2) == 0 ? 1 : 6); c > 0; c--) begin
                press_ready = $urandom_range(0, 3) == 0;
                overrun_clr = $urandom_range(0, 9) == 0;
                step();
            end
        end
        press_ready = 0; overrun_clr = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
